// File: rtl/vp_pkg.sv
// Shared types and defaults for the load value-prediction verify unit.
// A prediction entry pairs the load PC with the value handed to the pipeline.
package vp_pkg;

  localparam int ADDR_WIDTH       = 32;
  localparam int DATA_WIDTH       = 32;
  localparam int DEPTH_DEF        = 4;
  localparam int HOLD_CYCLES_DEF  = 3;
  localparam int CNT_WIDTH_DEF    = 16;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] data;
  } vp_entry_t;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    RECOVER = 2'd1,
    HOLD    = 2'd2
  } vp_state_e;

endpackage

// File: rtl/vp_pred_fifo.sv
// In-order FIFO of outstanding predictions; flush drops everything younger
// than the entry being popped in the same cycle.
module vp_pred_fifo
  import vp_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_push,
  input  vp_entry_t i_push_entry,
  input  logic      i_pop,
  input  logic      i_flush,
  output vp_entry_t o_head,
  output logic      o_full,
  output logic      o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  vp_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     w_rd_next;

  assign w_rd_next = r_rd_ptr + PW'(i_pop);

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_rd_ptr <= w_rd_next;
      if (i_flush) begin
        r_wr_ptr <= w_rd_next;
      end else if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_push_entry;
    end
  end

endmodule

// File: rtl/vp_verify_unit.sv
// Checks completing loads against the oldest outstanding value prediction,
// trains the predictor and requests pipeline recovery on a mispredict.
module vp_verify_unit
  import vp_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEF,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
  parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pred_valid,
  input  logic [ADDR_WIDTH-1:0] pred_pc,
  input  logic [DATA_WIDTH-1:0] pred_data,
  output logic                  pred_ready,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  recover,
  output logic [ADDR_WIDTH-1:0] recover_pc,
  output logic [DATA_WIDTH-1:0] recover_data,
  output logic                  train_valid,
  output logic [ADDR_WIDTH-1:0] train_pc,
  output logic [DATA_WIDTH-1:0] train_data,
  output logic                  train_hit,
  output logic                  spurious,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count,
  output logic [1:0]            dbg_state
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  vp_state_e             r_state;
  logic [HW-1:0]         r_hold_cnt;
  logic                  r_recover;
  logic [ADDR_WIDTH-1:0] r_recover_pc;
  logic [DATA_WIDTH-1:0] r_recover_data;
  logic                  r_train_valid;
  logic [ADDR_WIDTH-1:0] r_train_pc;
  logic [DATA_WIDTH-1:0] r_train_data;
  logic                  r_train_hit;
  logic                  r_spurious;
  logic [CNT_WIDTH-1:0]  r_hit_count;
  logic [CNT_WIDTH-1:0]  r_miss_count;

  logic                  w_active;
  logic                  w_full;
  logic                  w_empty;
  vp_entry_t             w_head;
  vp_entry_t             w_push_entry;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_hit;
  logic                  w_miss;
  logic                  w_spurious;

  assign w_active     = (r_state == ACTIVE);
  assign pred_ready   = !w_full && w_active;
  assign w_push       = pred_valid && pred_ready;
  // Completions outside ACTIVE belong to the squashed path and are ignored.
  assign w_pop        = mem_valid && !w_empty && w_active;
  assign w_spurious   = mem_valid && w_empty && w_active;
  assign w_hit        = (mem_data == w_head.data);
  assign w_miss       = w_pop && !w_hit;
  assign w_push_entry = '{pc: pred_pc, data: pred_data};

  vp_pred_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_flush      (w_miss),
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ACTIVE;
      r_hold_cnt     <= '0;
      r_recover      <= 1'b0;
      r_recover_pc   <= '0;
      r_recover_data <= '0;
      r_train_valid  <= 1'b0;
      r_train_pc     <= '0;
      r_train_data   <= '0;
      r_train_hit    <= 1'b0;
      r_spurious     <= 1'b0;
      r_hit_count    <= '0;
      r_miss_count   <= '0;
    end else begin
      r_train_valid <= w_pop;
      r_recover     <= w_miss;
      r_spurious    <= w_spurious;

      if (w_pop) begin
        r_train_pc   <= w_head.pc;
        r_train_data <= mem_data;
        r_train_hit  <= w_hit;
        if (w_hit) begin
          if (r_hit_count != '1) r_hit_count <= r_hit_count + CNT_WIDTH'(1);
        end else begin
          if (r_miss_count != '1) r_miss_count <= r_miss_count + CNT_WIDTH'(1);
        end
      end

      if (w_miss) begin
        r_recover_pc   <= w_head.pc;
        r_recover_data <= mem_data;
      end

      // HOLD spans HOLD_CYCLES cycles: the counter is loaded one short.
      case (r_state)
        ACTIVE: begin
          if (w_miss) r_state <= RECOVER;
        end
        RECOVER: begin
          r_state    <= HOLD;
          r_hold_cnt <= HW'(HOLD_CYCLES - 1);
        end
        HOLD: begin
          if (r_hold_cnt == '0) r_state <= ACTIVE;
          else                  r_hold_cnt <= r_hold_cnt - HW'(1);
        end
        default: r_state <= ACTIVE;
      endcase
    end
  end

  assign recover      = r_recover;
  assign recover_pc   = r_recover_pc;
  assign recover_data = r_recover_data;
  assign train_valid  = r_train_valid;
  assign train_pc     = r_train_pc;
  assign train_data   = r_train_data;
  assign train_hit    = r_train_hit;
  assign spurious     = r_spurious;
  assign hit_count    = r_hit_count;
  assign miss_count   = r_miss_count;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_vp_verify_unit.sv
// Directed and random stimulus for vp_verify_unit against a queue-based
// reference model; train results flow through an expected queue.
module tb_vp_verify_unit;

  localparam int DEPTH = 4;
  localparam int HOLD  = 3;
  localparam int EW    = 32 + 32 + 1;
  localparam int M_ACTIVE  = 0;
  localparam int M_RECOVER = 1;
  localparam int M_HOLD    = 2;

  logic        clk;
  logic        rst_n;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic [31:0] pred_data;
  logic        pred_ready;
  logic        mem_valid;
  logic [31:0] mem_data;
  logic        recover;
  logic [31:0] recover_pc;
  logic [31:0] recover_data;
  logic        train_valid;
  logic [31:0] train_pc;
  logic [31:0] train_data;
  logic        train_hit;
  logic        spurious;
  logic [15:0] hit_count;
  logic [15:0] miss_count;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  logic [63:0]   m_q[$];
  int            m_state;
  int            m_hold;
  int            m_hits;
  int            m_misses;
  logic [31:0]   m_rec_pc;
  logic [31:0]   m_rec_data;

  vp_verify_unit #(
    .DEPTH       (DEPTH),
    .HOLD_CYCLES (HOLD),
    .CNT_WIDTH   (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pred_valid   (pred_valid),
    .pred_pc      (pred_pc),
    .pred_data    (pred_data),
    .pred_ready   (pred_ready),
    .mem_valid    (mem_valid),
    .mem_data     (mem_data),
    .recover      (recover),
    .recover_pc   (recover_pc),
    .recover_data (recover_data),
    .train_valid  (train_valid),
    .train_pc     (train_pc),
    .train_data   (train_data),
    .train_hit    (train_hit),
    .spurious     (spurious),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .dbg_state    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    exp_q.delete();
    m_state    = M_ACTIVE;
    m_hold     = 0;
    m_hits     = 0;
    m_misses   = 0;
    m_rec_pc   = '0;
    m_rec_data = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pred_ready"}, pred_ready, 1);
    chk({tag, "_recover"}, recover, 0);
    chk({tag, "_recover_pc"}, recover_pc, 0);
    chk({tag, "_recover_data"}, recover_data, 0);
    chk({tag, "_train_valid"}, train_valid, 0);
    chk({tag, "_train_pc"}, train_pc, 0);
    chk({tag, "_train_data"}, train_data, 0);
    chk({tag, "_train_hit"}, train_hit, 0);
    chk({tag, "_spurious"}, spurious, 0);
    chk({tag, "_hit_count"}, hit_count, 0);
    chk({tag, "_miss_count"}, miss_count, 0);
  endtask

  // One clock of stimulus: model predicts, DUT is driven, outputs compared.
  task automatic drive_cycle(input logic pv, input logic [31:0] pc, input logic [31:0] pd,
                             input logic mv, input logic [31:0] md);
    logic          act, exp_rdy, pop, spur, hit, push;
    logic [63:0]   head;
    logic [EW-1:0] t;
    act     = (m_state == M_ACTIVE);
    exp_rdy = act && (m_q.size() < DEPTH);
    pop     = mv && act && (m_q.size() > 0);
    spur    = mv && act && (m_q.size() == 0);
    push    = pv && exp_rdy;
    hit     = 1'b0;
    head    = '0;
    pred_valid = pv;
    pred_pc    = pc;
    pred_data  = pd;
    mem_valid  = mv;
    mem_data   = md;
    chk("pred_ready", pred_ready, exp_rdy);
    if (pop) begin
      head = m_q.pop_front();
      hit  = (md == head[31:0]);
      exp_q.push_back({head[63:32], md, hit});
      if (hit) m_hits++;
      else     m_misses++;
    end
    case (m_state)
      M_ACTIVE: begin
        if (pop && !hit) begin
          m_q.delete();
          m_state    = M_RECOVER;
          m_rec_pc   = head[63:32];
          m_rec_data = md;
        end else if (push) begin
          m_q.push_back({pc, pd});
        end
      end
      M_RECOVER: begin
        m_state = M_HOLD;
        m_hold  = HOLD;
      end
      default: begin
        m_hold--;
        if (m_hold == 0) m_state = M_ACTIVE;
      end
    endcase
    @(posedge clk);
    #1;
    pred_valid = 1'b0;
    mem_valid  = 1'b0;
    chk("train_valid", train_valid, pop);
    chk("recover", recover, pop && !hit);
    chk("spurious", spurious, spur);
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_misses);
    chk("recover_pc", recover_pc, m_rec_pc);
    chk("recover_data", recover_data, m_rec_data);
    if (train_valid) begin
      if (exp_q.size() == 0) begin
        chk("train_unexpected", 1, 0);
      end else begin
        t = exp_q.pop_front();
        chk("train_pc", train_pc, t[64:33]);
        chk("train_data", train_data, t[32:1]);
        chk("train_hit", train_hit, t[0]);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, '0, '0, 0, '0);
  endtask

  task automatic push_pred(input logic [31:0] pc, input logic [31:0] pd);
    drive_cycle(1, pc, pd, 0, '0);
  endtask

  task automatic complete(input logic [31:0] md);
    drive_cycle(0, '0, '0, 1, md);
  endtask

  initial begin
    logic        pv, mv;
    logic [31:0] pc, pd, md;
    rst_n      = 1'b0;
    pred_valid = 1'b0;
    pred_pc    = '0;
    pred_data  = '0;
    mem_valid  = 1'b0;
    mem_data   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Spurious completion straight after reset leaves counters at zero.
    complete(32'h1234);
    idle(1);

    // Simple hit.
    push_pred(32'h100, 32'hA);
    complete(32'hA);
    idle(1);

    // Mispredict, then the refill window.
    push_pred(32'h200, 32'h5);
    complete(32'h7);
    chk("dbg_state_recover", dbg_state, 2'd1);
    idle(HOLD + 2);

    // Fill to DEPTH, drop a fifth, pop one, refill.
    for (int i = 0; i < DEPTH; i++) push_pred(32'h300 + i, 32'h10 + i);
    push_pred(32'h3FF, 32'h99);
    complete(32'h10);
    push_pred(32'h400, 32'h20);
    complete(32'h11);
    complete(32'h12);
    complete(32'h13);
    complete(32'h20);
    complete(32'h55);

    // Mispredict on the oldest of three flushes the rest; HOLD ignores completions.
    push_pred(32'h500, 32'h1);
    push_pred(32'h501, 32'h2);
    push_pred(32'h502, 32'h3);
    drive_cycle(1, 32'h503, 32'h4, 1, 32'hF);
    complete(32'h2);
    complete(32'h3);
    complete(32'h4);
    complete(32'h4);
    complete(32'h2);

    // Push and matching pop together while not full.
    push_pred(32'h700, 32'h8);
    drive_cycle(1, 32'h701, 32'h9, 1, 32'h8);
    complete(32'h9);

    // Asynchronous reset in the middle of HOLD.
    push_pred(32'h600, 32'h1);
    push_pred(32'h601, 32'h2);
    complete(32'h9);
    idle(2);
    chk("dbg_state_hold", dbg_state, 2'd2);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    complete(32'h5);
    push_pred(32'h800, 32'h6);
    complete(32'h6);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      pv = 1'($urandom_range(0, 1));
      pc = $urandom;
      pd = $urandom_range(0, 3);
      mv = 1'($urandom_range(0, 1));
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0) md = m_q[0][31:0];
      else md = $urandom_range(0, 3);
      drive_cycle(pv, pc, pd, mv, md);
    end
    idle(HOLD + 2);

    chk("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
